// File: rtl/ysyx_lsu_load_if.sv
// ---------------------------------------------------------------------------
// ysyx_lsu_pkg / ysyx_lsu_load_if
//
// Purpose: shared constants for the load responder (data width, load op
// codes) and the interface that bundles its EXU request port, its result
// port and its data-memory read bus.
//
// Signal summary (directions as seen by the load responder, modport master):
//   exu_ren       in   load request, level, held until the result is consumed
//   exu_raddr     in   byte address
//   exu_ralu      in   load op code (LB/LH/LW/LBU/LHU, anything else = LW)
//   out_rdata     out  extended load result
//   out_rvalid    out  one-cycle result strobe
//   out_misalign  out  result qualifier: misaligned, no bus access made
//   out_fault     out  result qualifier: bus returned an error
//   bus_arvalid   out  read address valid
//   bus_araddr    out  word-aligned read address
//   bus_arready   in   read address accepted
//   bus_rvalid    in   read data valid
//   bus_rdata     in   read word
//   bus_rresp     in   read response, 0 = OKAY
//   bus_rready    out  read data accepted
// The slave modport is the environment view (EXU plus memory).
// ---------------------------------------------------------------------------
package ysyx_lsu_pkg;
  localparam int XLEN = 32;

  localparam logic [4:0] YSYX_ALU_LB__ = 5'h10;
  localparam logic [4:0] YSYX_ALU_LH__ = 5'h11;
  localparam logic [4:0] YSYX_ALU_LW__ = 5'h12;
  localparam logic [4:0] YSYX_ALU_LBU_ = 5'h13;
  localparam logic [4:0] YSYX_ALU_LHU_ = 5'h14;
endpackage

interface ysyx_lsu_load_if;
  logic                          exu_ren;
  logic [ysyx_lsu_pkg::XLEN-1:0] exu_raddr;
  logic [4:0]                    exu_ralu;

  logic [ysyx_lsu_pkg::XLEN-1:0] out_rdata;
  logic                          out_rvalid;
  logic                          out_misalign;
  logic                          out_fault;

  logic                          bus_arvalid;
  logic [ysyx_lsu_pkg::XLEN-1:0] bus_araddr;
  logic                          bus_arready;
  logic                          bus_rvalid;
  logic [ysyx_lsu_pkg::XLEN-1:0] bus_rdata;
  logic [1:0]                    bus_rresp;
  logic                          bus_rready;

  modport master (
    input  exu_ren, exu_raddr, exu_ralu,
    input  bus_arready, bus_rvalid, bus_rdata, bus_rresp,
    output out_rdata, out_rvalid, out_misalign, out_fault,
    output bus_arvalid, bus_araddr, bus_rready
  );

  modport slave (
    output exu_ren, exu_raddr, exu_ralu,
    output bus_arready, bus_rvalid, bus_rdata, bus_rresp,
    input  out_rdata, out_rvalid, out_misalign, out_fault,
    input  bus_arvalid, bus_araddr, bus_rready
  );
endinterface

// File: rtl/ysyx_lsu_load.sv
// ---------------------------------------------------------------------------
// ysyx_lsu_load
//
// Purpose: load-side responder between the EXU and the data-memory read bus.
// Accepts one load at a time, issues a word-aligned read, extracts and
// extends the addressed byte/halfword/word and returns it with a one-cycle
// valid pulse. A pipeline flush drops the current load; a read already
// handed to the bus is drained silently so at most one read is outstanding.
//
// Ports:
//   clock           system clock
//   reset           synchronous, active-high reset
//   flush_pipeline  discard the current load (priority below reset only)
//   lsu             ysyx_lsu_load_if.master: EXU request, result, read bus
// ---------------------------------------------------------------------------
module ysyx_lsu_load
  import ysyx_lsu_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             flush_pipeline,
  ysyx_lsu_load_if.master  lsu
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]      state_q,    state_d;
  logic [1:0]      lane_q,     lane_d;
  logic [4:0]      op_q,       op_d;
  logic [XLEN-1:0] araddr_q,   araddr_d;
  logic [XLEN-1:0] rdata_q,    rdata_d;
  logic            misalign_q, misalign_d;
  logic            fault_q,    fault_d;

  logic ar_hs;

  // Halfwords need an even address, words (and unknown ops) a 4-byte one.
  function automatic logic is_misaligned(input logic [4:0] op, input logic [1:0] lane);
    case (op)
      YSYX_ALU_LB__, YSYX_ALU_LBU_: is_misaligned = 1'b0;
      YSYX_ALU_LH__, YSYX_ALU_LHU_: is_misaligned = lane[0];
      default:                      is_misaligned = (lane != 2'b00);
    endcase
  endfunction

  function automatic logic [XLEN-1:0] format_load(input logic [4:0]      op,
                                                  input logic [1:0]      lane,
                                                  input logic [XLEN-1:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (op)
      YSYX_ALU_LB__: format_load = {{(XLEN-8){b[7]}}, b};
      YSYX_ALU_LBU_: format_load = {{(XLEN-8){1'b0}}, b};
      YSYX_ALU_LH__: format_load = {{(XLEN-16){h[15]}}, h};
      YSYX_ALU_LHU_: format_load = {{(XLEN-16){1'b0}}, h};
      default:       format_load = word;
    endcase
  endfunction

  assign ar_hs = (state_q == S_REQ) && lsu.bus_arready;

  always_comb begin
    // NOTE: every next-state signal takes its held value first, so no path
    // through the case below can leave one unassigned and infer a latch.
    state_d    = state_q;
    lane_d     = lane_q;
    op_d       = op_q;
    araddr_d   = araddr_q;
    rdata_d    = rdata_q;
    misalign_d = misalign_q;
    fault_d    = fault_q;

    case (state_q)
      S_IDLE: begin
        if (!flush_pipeline && lsu.exu_ren) begin
          lane_d  = lsu.exu_raddr[1:0];
          op_d    = lsu.exu_ralu;
          fault_d = 1'b0;
          if (is_misaligned(lsu.exu_ralu, lsu.exu_raddr[1:0])) begin
            state_d    = S_RESP;
            misalign_d = 1'b1;
            rdata_d    = '0;
          end else begin
            state_d    = S_REQ;
            misalign_d = 1'b0;
            araddr_d   = {lsu.exu_raddr[XLEN-1:2], 2'b00};
          end
        end
      end

      // A read the bus has already taken must still be drained on flush.
      S_REQ: begin
        if (ar_hs)               state_d = flush_pipeline ? S_DRAIN : S_WAIT;
        else if (flush_pipeline) state_d = S_IDLE;
      end

      S_WAIT: begin
        if (lsu.bus_rvalid) begin
          if (flush_pipeline) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_RESP;
            fault_d = (lsu.bus_rresp != 2'b00);
            rdata_d = (lsu.bus_rresp != 2'b00) ? '0
                    : format_load(op_q, lane_q, lsu.bus_rdata);
          end
        end else if (flush_pipeline) begin
          state_d = S_DRAIN;
        end
      end

      // exu_ren is deliberately ignored here: the EXU retargets it at the
      // edge that ends RESP, so sampling it would re-accept the same load.
      S_RESP:  state_d = S_IDLE;

      S_DRAIN: if (lsu.bus_rvalid) state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values
    // regardless of statement order.
    if (reset) begin
      state_q    <= S_IDLE;
      lane_q     <= 2'b00;
      op_q       <= 5'd0;
      araddr_q   <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      op_q       <= op_d;
      araddr_q   <= araddr_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
      fault_q    <= fault_d;
    end
  end

  // A flush landing in RESP withdraws the result so a squashed load is
  // never captured by the reservation station.
  assign lsu.out_rvalid   = (state_q == S_RESP) && !flush_pipeline;
  assign lsu.out_misalign = (state_q == S_RESP) && misalign_q;
  assign lsu.out_fault    = (state_q == S_RESP) && fault_q;
  assign lsu.out_rdata    = rdata_q;

  assign lsu.bus_arvalid  = (state_q == S_REQ);
  assign lsu.bus_araddr   = araddr_q;
  assign lsu.bus_rready   = (state_q == S_WAIT) || (state_q == S_DRAIN);

endmodule

// File: tb/tb_ysyx_lsu_load.sv
// ---------------------------------------------------------------------------
// tb_ysyx_lsu_load
//
// Self-checking bench for ysyx_lsu_load. An EXU driver issues loads and
// pushes the expected result (data, qualifiers, arrival cycle) into a queue;
// a memory responder serves reads from a second queue with per-read wait
// states; a monitor pops and compares whenever out_rvalid is seen.
// ---------------------------------------------------------------------------
module tb_ysyx_lsu_load;
  import ysyx_lsu_pkg::*;

  logic clock = 1'b0;
  logic reset;
  logic flush_pipeline;

  always #5 clock = ~clock;

  ysyx_lsu_load_if lsu ();

  ysyx_lsu_load dut (
    .clock          (clock),
    .reset          (reset),
    .flush_pipeline (flush_pipeline),
    .lsu            (lsu)
  );

  typedef struct {
    logic [31:0] data;
    logic        mis;
    logic        flt;
    int unsigned cyc;
  } exp_t;

  typedef struct {
    logic [31:0] araddr;
    logic [31:0] word;
    logic [1:0]  resp;
    int unsigned ard;
    int unsigned rd;
  } mem_t;

  exp_t exp_q[$];
  mem_t mem_q[$];

  int unsigned cyc = 0;
  int n_checks = 0;
  int n_fail   = 0;
  int reads     = 0;
  int exp_reads = 0;

  logic        ar_hs_q = 1'b0;
  logic        r_hs_q  = 1'b0;
  logic [31:0] ar_addr_q = '0;

  always @(posedge clock) begin
    cyc       <= cyc + 1;
    ar_hs_q   <= lsu.bus_arvalid & lsu.bus_arready;
    r_hs_q    <= lsu.bus_rvalid & lsu.bus_rready;
    ar_addr_q <= lsu.bus_araddr;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned op_size(input logic [4:0] op);
    if (op == YSYX_ALU_LB__ || op == YSYX_ALU_LBU_) return 1;
    if (op == YSYX_ALU_LH__ || op == YSYX_ALU_LHU_) return 2;
    return 4;
  endfunction

  function automatic bit op_signed(input logic [4:0] op);
    return (op == YSYX_ALU_LB__ || op == YSYX_ALU_LH__);
  endfunction

  function automatic exp_t model(input logic [4:0] op, input logic [31:0] addr,
                                 input logic [31:0] word, input logic [1:0] resp,
                                 input int unsigned t, input int unsigned ard,
                                 input int unsigned rd);
    exp_t e;
    int unsigned sz;
    longint unsigned w, span, v;
    sz    = op_size(op);
    e.mis = ((addr % sz) != 0);
    e.flt = 1'b0;
    e.data = '0;
    if (e.mis) begin
      e.cyc = t + 1;
    end else begin
      e.cyc = t + 3 + ard + rd;
      if (resp != 2'b00) begin
        e.flt = 1'b1;
      end else begin
        w    = word;
        span = 64'd1 << (8 * sz);
        v    = (w >> (8 * (addr % 4))) % span;
        if (op_signed(op) && v >= span / 2) v = v - span;
        e.data = v[31:0];
      end
    end
    return e;
  endfunction

  // ---------------- EXU driver helpers ----------------
  task automatic push_mem(input logic [31:0] addr, input logic [31:0] word,
                          input logic [1:0] resp, input int unsigned ard,
                          input int unsigned rd);
    mem_t m;
    m.araddr = addr - (addr % 4);
    m.word   = word;
    m.resp   = resp;
    m.ard    = ard;
    m.rd     = rd;
    mem_q.push_back(m);
  endtask

  // Called at a negedge with the DUT idle; that cycle is the accept cycle.
  task automatic issue(input logic [4:0] op, input logic [31:0] addr,
                       input logic [31:0] word, input logic [1:0] resp,
                       input int unsigned ard, input int unsigned rd);
    exp_t e;
    e = model(op, addr, word, resp, cyc, ard, rd);
    if (!e.mis) begin
      push_mem(addr, word, resp, ard, rd);
      exp_reads++;
    end
    exp_q.push_back(e);
    lsu.exu_ren   = 1'b1;
    lsu.exu_raddr = addr;
    lsu.exu_ralu  = op;
  endtask

  // Holds exu_ren through RESP and drops it at the edge ending RESP.
  task automatic wait_resp();
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!lsu.out_rvalid && n < 60);
    if (!lsu.out_rvalid) check("resp_timeout", 32'd0, 32'd1);
    @(posedge clock);
    #1;
    lsu.exu_ren = 1'b0;
  endtask

  task automatic load(input logic [4:0] op, input logic [31:0] addr,
                      input logic [31:0] word, input logic [1:0] resp,
                      input int unsigned ard, input int unsigned rd);
    issue(op, addr, word, resp, ard, rd);
    wait_resp();
  endtask

  // ---------------- memory responder ----------------
  initial begin : responder
    mem_t        cur;
    int unsigned ar_cnt;
    int unsigned r_cnt;
    bit          busy;
    ar_cnt = 0;
    r_cnt  = 0;
    busy   = 1'b0;
    cur    = '{araddr: '0, word: '0, resp: '0, ard: 0, rd: 0};
    lsu.bus_arready = 1'b0;
    lsu.bus_rvalid  = 1'b0;
    lsu.bus_rdata   = '0;
    lsu.bus_rresp   = 2'b00;
    forever begin
      @(negedge clock);
      if (reset) begin
        lsu.bus_arready = 1'b0;
        lsu.bus_rvalid  = 1'b0;
        busy   = 1'b0;
        ar_cnt = 0;
      end else begin
        if (r_hs_q) begin
          lsu.bus_rvalid = 1'b0;
          busy = 1'b0;
        end
        if (ar_hs_q) begin
          lsu.bus_arready = 1'b0;
          ar_cnt = 0;
          r_cnt  = 0;
          reads++;
          if (mem_q.size() == 0) begin
            check("unexpected_read", 32'd1, 32'd0);
            cur = '{araddr: ar_addr_q, word: '0, resp: '0, ard: 0, rd: 0};
          end else begin
            cur = mem_q.pop_front();
          end
          check("araddr", ar_addr_q, cur.araddr);
          busy = 1'b1;
        end
        if (!busy) begin
          if (lsu.bus_arvalid) begin
            if (mem_q.size() > 0 && ar_cnt < mem_q[0].ard) begin
              lsu.bus_arready = 1'b0;
              ar_cnt++;
            end else begin
              lsu.bus_arready = 1'b1;
            end
          end else begin
            lsu.bus_arready = 1'b0;
            ar_cnt = 0;
          end
        end else if (!lsu.bus_rvalid) begin
          if (r_cnt < cur.rd) begin
            r_cnt++;
          end else begin
            lsu.bus_rvalid = 1'b1;
            lsu.bus_rdata  = cur.word;
            lsu.bus_rresp  = cur.resp;
          end
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset && lsu.out_rvalid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rvalid: got out_rvalid=1 want 0 (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          check("rdata",    lsu.out_rdata,           e.data);
          check("misalign", {31'd0, lsu.out_misalign}, {31'd0, e.mis});
          check("fault",    {31'd0, lsu.out_fault},    {31'd0, e.flt});
          check("latency",  cyc,                     e.cyc);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    int unsigned t0;
    logic [4:0]  op;
    logic [31:0] addr;
    logic [1:0]  resp;
    exp_t        e;

    reset          = 1'b1;
    flush_pipeline = 1'b0;
    lsu.exu_ren    = 1'b0;
    lsu.exu_raddr  = '0;
    lsu.exu_ralu   = 5'd0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_rvalid",   {31'd0, lsu.out_rvalid},   32'd0);
    check("rst_misalign", {31'd0, lsu.out_misalign}, 32'd0);
    check("rst_fault",    {31'd0, lsu.out_fault},    32'd0);
    check("rst_arvalid",  {31'd0, lsu.bus_arvalid},  32'd0);
    check("rst_rready",   {31'd0, lsu.bus_rready},   32'd0);
    check("rst_araddr",   lsu.bus_araddr,            32'd0);
    check("rst_rdata",    lsu.out_rdata,             32'd0);
    #1 reset = 1'b0;

    // Directed loads through the scoreboard.
    @(negedge clock); load(YSYX_ALU_LB__, 32'h8000_0003, 32'h80FF_1234, 2'd0, 0, 0);
    @(negedge clock); load(YSYX_ALU_LHU_, 32'h8000_0002, 32'h80FF_1234, 2'd0, 0, 0);
    @(negedge clock); load(YSYX_ALU_LH__, 32'h8000_0002, 32'h80FF_1234, 2'd0, 0, 0);
    @(negedge clock); load(YSYX_ALU_LW__, 32'h8000_0004, 32'hDEAD_BEEF, 2'd0, 3, 0);
    @(negedge clock); load(YSYX_ALU_LW__, 32'h8000_0006, 32'h1111_1111, 2'd0, 0, 0);
    @(negedge clock); load(YSYX_ALU_LH__, 32'h8000_0001, 32'h2222_2222, 2'd0, 0, 0);
    @(negedge clock); load(YSYX_ALU_LW__, 32'h8000_0008, 32'h1234_5678, 2'd2, 0, 1);
    @(negedge clock); load(YSYX_ALU_LBU_, 32'h8000_0001, 32'h80FF_1234, 2'd0, 1, 2);
    @(negedge clock); load(YSYX_ALU_LH__, 32'h8000_0000, 32'h0000_9ABC, 2'd0, 0, 0);
    check("reads_directed", reads, exp_reads);

    // Flush in WAIT; read data arrives two cycles later and is drained.
    // exu_ren stays high and must only be accepted the cycle after rvalid.
    @(negedge clock);
    t0 = cyc;
    push_mem(32'h8000_0010, 32'hAAAA_5555, 2'd0, 0, 2);
    exp_reads++;
    lsu.exu_ren   = 1'b1;
    lsu.exu_raddr = 32'h8000_0010;
    lsu.exu_ralu  = YSYX_ALU_LW__;
    @(negedge clock);                      // t0+1 REQ
    @(negedge clock);                      // t0+2 WAIT
    flush_pipeline = 1'b1;
    @(negedge clock);                      // t0+3 DRAIN
    flush_pipeline = 1'b0;
    check("drain_arvalid_t3", {31'd0, lsu.bus_arvalid}, 32'd0);
    check("drain_rready_t3",  {31'd0, lsu.bus_rready},  32'd1);
    push_mem(32'h8000_0010, 32'h0BAD_F00D, 2'd0, 0, 0);
    exp_reads++;
    e = model(YSYX_ALU_LW__, 32'h8000_0010, 32'h0BAD_F00D, 2'd0, t0 + 5, 0, 0);
    exp_q.push_back(e);
    @(negedge clock);                      // t0+4 DRAIN, rvalid
    check("drain_arvalid_t4", {31'd0, lsu.bus_arvalid}, 32'd0);
    @(negedge clock);                      // t0+5 IDLE, accepts
    check("drain_arvalid_t5", {31'd0, lsu.bus_arvalid}, 32'd0);
    @(negedge clock);                      // t0+6 REQ
    check("reaccept_arvalid", {31'd0, lsu.bus_arvalid}, 32'd1);
    wait_resp();

    // Flush in REQ while arready is low: arvalid drops, no read happens.
    @(negedge clock);
    push_mem(32'h8000_0020, 32'h5A5A_5A5A, 2'd0, 5, 0);
    lsu.exu_ren   = 1'b1;
    lsu.exu_raddr = 32'h8000_0020;
    lsu.exu_ralu  = YSYX_ALU_LW__;
    @(negedge clock);
    check("req_arvalid", {31'd0, lsu.bus_arvalid}, 32'd1);
    flush_pipeline = 1'b1;
    lsu.exu_ren    = 1'b0;
    @(negedge clock);
    flush_pipeline = 1'b0;
    check("reqflush_arvalid", {31'd0, lsu.bus_arvalid}, 32'd0);
    check("reqflush_rready",  {31'd0, lsu.bus_rready},  32'd0);
    @(negedge clock);
    check("reqflush_arvalid2", {31'd0, lsu.bus_arvalid}, 32'd0);
    check("reqflush_rready2",  {31'd0, lsu.bus_rready},  32'd0);
    if (mem_q.size() > 0) void'(mem_q.pop_front());
    check("reads_after_reqflush", reads, exp_reads);

    // Reset while waiting for read data.
    @(negedge clock);
    issue(YSYX_ALU_LW__, 32'h8000_0030, 32'h7777_8888, 2'd0, 0, 4);
    @(negedge clock);                      // REQ
    @(negedge clock);                      // WAIT
    #1;
    reset       = 1'b1;
    lsu.exu_ren = 1'b0;
    @(negedge clock);
    check("rstwait_arvalid", {31'd0, lsu.bus_arvalid}, 32'd0);
    check("rstwait_rready",  {31'd0, lsu.bus_rready},  32'd0);
    check("rstwait_rvalid",  {31'd0, lsu.out_rvalid},  32'd0);
    check("rstwait_rdata",   lsu.out_rdata,            32'd0);
    exp_q.delete();
    #1 reset = 1'b0;
    @(negedge clock);
    @(negedge clock); load(YSYX_ALU_LB__, 32'h8000_0042, 32'h00C3_0000, 2'd0, 0, 0);

    // Randomized loads, back-to-back or with small gaps.
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 5))
        0:       op = YSYX_ALU_LB__;
        1:       op = YSYX_ALU_LH__;
        2:       op = YSYX_ALU_LW__;
        3:       op = YSYX_ALU_LBU_;
        4:       op = YSYX_ALU_LHU_;
        default: op = 5'($urandom_range(0, 31));
      endcase
      addr = 32'h8000_0000 + ($urandom & 32'h0000_0FFF);
      resp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      @(negedge clock);
      repeat ($urandom_range(0, 2)) @(negedge clock);
      load(op, addr, $urandom, resp, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    repeat (4) @(negedge clock);
    check("exp_q_empty", exp_q.size(), 32'd0);
    check("mem_q_empty", mem_q.size(), 32'd0);
    check("reads_total", reads, exp_reads);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
